// File: rtl/uart_rx_frame.sv
// uart_rx_frame: serial-to-parallel UART receiver, 8 data bits LSB first,
// one start bit and one stop bit. Each bit is timed with a per-bit cycle
// counter and decided by a 3-sample majority vote around mid-bit.
// Optional feature macro: UART_PARITY_EN adds a parity bit (sense set by
// PARITY_ODD) between the data bits and the stop bit, plus the parity_err port.
module uart_rx_frame #(
  parameter int BPS_MAX    = 5208,  // clk cycles per bit, minimum 4
  parameter int PARITY_ODD = 0      // 0 = even parity, 1 = odd parity
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CW  = (BPS_MAX > 1) ? $clog2(BPS_MAX) : 1;
  localparam int MID = BPS_MAX / 2;

  // Counter values at which the three votes are taken and the bit ends.
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_MAX - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

`ifdef UART_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
`endif

  // Reject parameter values the bit timing cannot support.
  if (BPS_MAX < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_rx_frame: BPS_MAX must be >= 4 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_reg;
  logic [2:0]      sync_reg;     // [0],[1]: synchroniser, [2]: rx_s one cycle ago
  logic [CW-1:0]   bps_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [1:0]      samp_reg;     // votes taken at MID-1 and MID
  logic [7:0]      shift_reg;
`ifdef UART_PARITY_EN
  logic            par_bit_reg;
`endif

  logic rx_s;
  logic rx_prev;
  logic fall;
  logic maj;

  assign rx_s    = sync_reg[1];
  assign rx_prev = sync_reg[2];
  assign fall    = rx_prev & ~rx_s;

  // Third vote is the live synchronised sample at the decision cycle.
  assign maj = (samp_reg[0] & samp_reg[1]) |
               (samp_reg[0] & rx_s)        |
               (samp_reg[1] & rx_s);

  // Bring rx into the clock domain; all stages reset to the idle-high level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], rx};
    end
  end

  // Frame state machine: bit timing, vote capture, shifting and result pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bps_cnt_reg <= '0;
      bit_idx_reg <= '0;
      samp_reg    <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit_reg <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      // Result flags are single-cycle pulses.
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state_reg == IDLE) begin
        bps_cnt_reg <= '0;
        // Only a genuine 1->0 transition starts a frame; a held-low line does not.
        if (fall) begin
          state_reg <= START;
          busy      <= 1'b1;
        end
      end else begin
        bps_cnt_reg <= (bps_cnt_reg == CNT_LAST) ? '0 : bps_cnt_reg + 1'b1;

        if (bps_cnt_reg == CNT_S0) samp_reg[0] <= rx_s;
        if (bps_cnt_reg == CNT_S1) samp_reg[1] <= rx_s;

        // Bit boundary: advance to the next bit of the frame.
        if (bps_cnt_reg == CNT_LAST) begin
          case (state_reg)
            START: begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end
            DATA: begin
              if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end else begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
              end
            end
`ifdef UART_PARITY_EN
            PARITY:  state_reg <= STOP;
`endif
            default: ;
          endcase
        end

        // Decision cycle. Placed after the boundary logic so that, at the
        // smallest BPS_MAX where both coincide, a false start still wins.
        if (bps_cnt_reg == CNT_DEC) begin
          case (state_reg)
            START: begin
              if (maj) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end
            DATA: shift_reg[bit_idx_reg] <= maj;
`ifdef UART_PARITY_EN
            PARITY: par_bit_reg <= maj;
`endif
            STOP: begin
              if (!maj) begin
                frame_err <= 1'b1;
`ifdef UART_PARITY_EN
              end else if ((^shift_reg ^ par_bit_reg) != PAR_SENSE) begin
                parity_err <= 1'b1;
`endif
              end else begin
                rx_data  <= shift_reg;
                rx_ready <= 1'b1;
              end
              // Leave half a stop bit early so a following start edge is seen.
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame at BPS_MAX=16.
// Expected result events are queued when a frame is driven and compared
// when rx_ready / frame_err / parity_err pulse. Define UART_PARITY_EN to
// exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int BPS  = 16;
  localparam int MID  = BPS / 2;
  localparam int PODD = 0;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Drive cycle of the start bit to pulse cycle: 2 synchroniser cycles to the
  // detected edge, then 1 + (NBITS-1)*BPS + MID + 2.
  localparam int LAT = 2 + 1 + (NBITS - 1) * BPS + MID + 2;

  localparam logic [2:0] K_RDY = 3'b001;
  localparam logic [2:0] K_FRM = 3'b010;
  localparam logic [2:0] K_PAR = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_frame #(
    .BPS_MAX    (BPS),
    .PARITY_ODD (PODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
`ifdef UART_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

`ifndef UART_PARITY_EN
  assign parity_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame starting at the current negedge and queue its outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic bad_par, input logic glitch);
    exp_t e;
    logic [NBITS-1:0] bits;
    int d0;
    d0 = cyc;
    bits = '0;
    bits[8:1] = d;
    bits[NBITS-1] = stop_v;
`ifdef UART_PARITY_EN
    bits[9] = (^d) ^ 1'(PODD) ^ bad_par;
`endif
    e.cyc = d0 + LAT;
    if (!stop_v) begin
      e.kind = K_FRM;
      e.data = last_good;
`ifdef UART_PARITY_EN
    end else if (bad_par) begin
      e.kind = K_PAR;
      e.data = last_good;
`endif
    end else begin
      e.kind = K_RDY;
      e.data = d;
      last_good = d;
    end
    sb_q.push_back(e);
    for (int j = 0; j < NBITS; j++) begin
      for (int k = 0; k < BPS; k++) begin
        // Optional one-cycle glitch lands on the receiver's middle vote.
        rx = (glitch && j >= 1 && j <= 8 && k == MID + 1) ? ~bits[j] : bits[j];
        if (j == 0 && k == 2) check_val("busy_before_start", 32'(busy), 32'd0);
        if (j == 0 && k == 3) check_val("busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
  endtask

  // Scoreboard side: every result pulse must match the next queued outcome.
  always @(negedge clk) begin : mon
    logic [2:0] ev;
    exp_t       e;
    ev = {parity_err, frame_err, rx_ready};
    if (ev != 3'b000) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_event", 32'(ev), 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("cycle %0d: event kind=%03b rx_data=0x%02h (expected kind=%03b data=0x%02h cycle=%0d)",
                 cyc, ev, rx_data, e.kind, e.data, e.cyc);
        check_val("event_kind", 32'(ev), 32'(e.kind));
        check_val("event_cycle", 32'(cyc), 32'(e.cyc));
        check_val("event_rx_data", 32'(rx_data), 32'(e.data));
        check_val("busy_low_at_event", 32'(busy), 32'd0);
      end
    end
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required end of test", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b0;
    rx  = 1'b1;

    // Reset held with the line toggling: everything stays cleared.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = ~rx;
      if (i == 5 || i == 19)
        check_val("reset_outputs", 32'({rx_data, rx_ready, frame_err, busy, parity_err}), 32'd0);
    end
    @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    idle(5);
    check_val("post_reset_outputs", 32'({rx_data, rx_ready, frame_err, busy, parity_err}), 32'd0);

    // Clean frame.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);

    // False start: 4 low cycles only.
    d0 = cyc;
    rx = 1'b0;
    wait_until(d0 + 3);
    check_val("false_start_busy_rise", 32'(busy), 32'd1);
    wait_until(d0 + 4);
    rx = 1'b1;
    wait_until(d0 + 12);
    check_val("false_start_busy_decide", 32'(busy), 32'd1);
    wait_until(d0 + 13);
    check_val("false_start_busy_fall", 32'(busy), 32'd0);
    idle(20);
    check_val("false_start_rx_data", 32'(rx_data), 32'h A5);

    // Bad stop bit, then a held-low line must not start a new frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check_val("break_no_retrigger_busy", 32'(busy), 32'd0);
    check_val("break_rx_data", 32'(rx_data), 32'h A5);
    idle(5);

    // Mid-bit glitches are outvoted.
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    idle(10);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h64, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(20);

`ifdef UART_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle(20);
`endif

    // Reset in the middle of a frame aborts it silently.
    rx = 1'b0;
    repeat (BPS) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_val("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_val("abort_outputs", 32'({rx_data, rx_ready, frame_err, busy, parity_err}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(200);
    check_val("abort_rx_data", 32'(rx_data), 32'd0);
    check_val("abort_busy_after", 32'(busy), 32'd0);

    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
